// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_reader
// Brief    : FIFO read-side consumer. Pops the FIFO, absorbs its 1-cycle read
//            latency in a 2-entry buffer, delivers words on valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_reader #(
    parameter int BITNUMBER = 8,
    parameter int LENGTH    = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [BITNUMBER-1:0] fifo_data_out,
    output logic                 fifo_rd,
    output logic [BITNUMBER-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [CNT_W-1:0]     word_count,
    output logic                 idle
);

    generate
        if (LENGTH < 2) begin : g_length_check
            $error("fifo_reader: LENGTH must be at least 2");
        end
    endgenerate

    logic [1:0]           occ_q, occ_d;
    logic                 inflight_q, inflight_d;
    logic [BITNUMBER-1:0] buf0_q, buf0_d;
    logic [BITNUMBER-1:0] buf1_q, buf1_d;
    logic                 valid_q, valid_d;
    logic [BITNUMBER-1:0] data_q, data_d;
    logic [CNT_W-1:0]     word_count_q, word_count_d;

    logic                 w_pop;
    logic                 w_rd;
    logic [1:0]           w_level;
    logic [1:0]           w_cap_idx;

    always_comb begin
        w_pop = valid_q & ready_in;
        // Occupancy after this edge; at most 3, and a pop implies occ >= 1.
        w_level = occ_q + {1'b0, inflight_q} - {1'b0, w_pop};
        w_rd = reset & enable & ~fifo_empty & (w_level < 2'd2);
        w_cap_idx = occ_q - {1'b0, w_pop};

        inflight_d = w_rd;

        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (w_pop) begin
            buf0_d = buf1_q;
        end
        if (inflight_q) begin
            if (w_cap_idx == 2'd0) begin
                buf0_d = fifo_data_out;
            end else begin
                buf1_d = fifo_data_out;
            end
        end

        occ_d        = w_level;
        valid_d      = (occ_d != 2'd0);
        data_d       = buf0_d;
        word_count_d = word_count_q + {{(CNT_W-1){1'b0}}, w_pop};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            word_count_q <= '0;
        end else begin
            occ_q        <= occ_d;
            inflight_q   <= inflight_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            word_count_q <= word_count_d;
        end
    end

    assign fifo_rd    = w_rd;
    assign valid_out  = valid_q;
    assign data_out   = data_q;
    assign word_count = word_count_q;
    assign idle       = ~reset | ((occ_q == 2'd0) & ~inflight_q & (~enable | fifo_empty));

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// Directed bench for fifo_reader: a small registered-flag FIFO model feeds the
// reader; delivered words are logged and compared with hand-computed values.
module tb_fifo_reader;
    localparam int BITNUMBER = 8;
    localparam int LENGTH    = 8;
    localparam int CNT_W     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, enable, fifo_empty, ready_in;
    logic                 fifo_rd, valid_out, idle;
    logic [BITNUMBER-1:0] fifo_data_out, data_out;
    logic [CNT_W-1:0]     word_count;
    logic                 push;
    logic [BITNUMBER-1:0] push_data;

    int total = 0;
    int bad   = 0;

    fifo_reader #(
        .BITNUMBER(BITNUMBER),
        .LENGTH   (LENGTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_data_out(fifo_data_out),
        .fifo_rd      (fifo_rd),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .word_count   (word_count),
        .idle         (idle)
    );

    // FIFO model: registered empty flag, read data valid the cycle after the pop.
    logic [BITNUMBER-1:0] mem [LENGTH];
    logic [2:0] wp, rp;
    logic [3:0] cnt, cnt_nx;
    logic       pop_ok;

    always_comb begin
        pop_ok = fifo_rd & ~fifo_empty;
        cnt_nx = cnt + {3'b000, push} - {3'b000, pop_ok};
    end

    always @(posedge clk) begin
        if (!reset) begin
            wp            <= 3'd0;
            rp            <= 3'd0;
            cnt           <= 4'd0;
            fifo_empty    <= 1'b1;
            fifo_data_out <= '0;
        end else begin
            if (push) begin
                mem[wp] <= push_data;
                wp      <= wp + 3'd1;
            end
            if (pop_ok) begin
                fifo_data_out <= mem[rp];
                rp            <= rp + 3'd1;
            end
            cnt        <= cnt_nx;
            fifo_empty <= (cnt_nx == 4'd0);
        end
    end

    logic [BITNUMBER-1:0] log_mem [128];
    logic [6:0]           nlog = 7'd0;
    int                   rd_pulses = 0;
    int                   spurious  = 0;

    always @(posedge clk) begin
        if (reset && valid_out && ready_in) begin
            log_mem[nlog] <= data_out;
            nlog          <= nlog + 7'd1;
        end
        if (fifo_rd) rd_pulses <= rd_pulses + 1;
        if (fifo_rd && fifo_empty) spurious <= spurious + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        enable   = 1'b0;
        ready_in = 1'b0;
        push     = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    task automatic load(input logic [BITNUMBER-1:0] v);
        push      = 1'b1;
        push_data = v;
        cyc();
        push = 1'b0;
    endtask

    logic [7:0]  rd_mask, vo_mask;
    logic [9:0]  vo_mask10;
    logic [6:0]  base;
    logic [3:0]  wc15, wc16;
    logic        acc;
    int          r0, unstable, errs;
    logic [7:0]  exp_b;

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        ready_in  = 1'b0;
        push      = 1'b0;
        push_data = '0;
        cyc();
        cyc();
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_wc", 32'(word_count), 32'd0);
        check("rst_rd", 32'(fifo_rd), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        reset = 1'b1;

        // Streaming A,B,C,D
        do_reset();
        load(8'h0A); load(8'h0B); load(8'h0C); load(8'h0D);
        base = nlog;
        enable = 1'b1;
        ready_in = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            rd_mask[k] = fifo_rd;
            vo_mask[k] = valid_out;
            cyc();
        end
        check("s_rd_mask", 32'(rd_mask), 32'h0F);
        check("s_vo_mask", 32'(vo_mask), 32'h3C);
        check("s_count", 32'(7'(nlog - base)), 32'd4);
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'h0A + 8'(i);
            check($sformatf("s_word%0d", i), 32'(log_mem[7'(base + 7'(i))]), 32'(exp_b));
        end
        check("s_wc", 32'(word_count), 32'd4);
        check("s_idle", 32'(idle), 32'd1);

        // Back-pressure with 1..8
        do_reset();
        for (int v = 1; v <= 8; v++) load(8'(v));
        base = nlog;
        r0 = rd_pulses;
        unstable = 0;
        enable = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (valid_out && data_out !== 8'h01) unstable++;
            cyc();
        end
        check("bp_rd_pulses", 32'(rd_pulses - r0), 32'd2);
        check("bp_valid", 32'(valid_out), 32'd1);
        check("bp_data", 32'(data_out), 32'h01);
        check("bp_stable", 32'(unstable), 32'd0);
        ready_in = 1'b1;
        #1;
        check("bp_rd_resume", 32'(fifo_rd), 32'd1);
        for (int k = 0; k < 10; k++) begin
            vo_mask10[k] = valid_out;
            cyc();
        end
        check("bp_vo_mask", 32'(vo_mask10), 32'h0FF);
        check("bp_count", 32'(7'(nlog - base)), 32'd8);
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            if (log_mem[7'(base + 7'(i))] !== 8'(i + 1)) errs++;
        end
        check("bp_order", 32'(errs), 32'd0);
        check("bp_wc", 32'(word_count), 32'd8);

        // Empty FIFO
        do_reset();
        enable = 1'b1;
        ready_in = 1'b1;
        acc = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            acc = acc | fifo_rd | valid_out;
            cyc();
        end
        check("e_activity", 32'(acc), 32'd0);
        check("e_idle", 32'(idle), 32'd1);

        // Enable drop: AA,BB pass, CC waits until enable returns
        do_reset();
        load(8'hAA); load(8'hBB); load(8'hCC);
        base = nlog;
        enable = 1'b1;
        ready_in = 1'b1;
        #1;
        check("en_rd0", 32'(fifo_rd), 32'd1);
        cyc();
        check("en_rd1", 32'(fifo_rd), 32'd1);
        cyc();
        enable = 1'b0;
        repeat (8) cyc();
        check("en_count", 32'(7'(nlog - base)), 32'd2);
        check("en_w0", 32'(log_mem[base]), 32'hAA);
        check("en_w1", 32'(log_mem[7'(base + 7'd1)]), 32'hBB);
        check("en_left", 32'(cnt), 32'd1);
        check("en_empty", 32'(fifo_empty), 32'd0);
        enable = 1'b1;
        repeat (6) cyc();
        check("en_w2", 32'(log_mem[7'(base + 7'd2)]), 32'hCC);
        check("en_wc", 32'(word_count), 32'd3);

        // Reset mid-stream with a word buffered and a read in flight
        do_reset();
        for (int v = 0; v < 6; v++) load(8'h51 + 8'(v));
        enable = 1'b1;
        ready_in = 1'b1;
        #1;
        repeat (4) cyc();
        check("mr_wc_before", 32'(word_count), 32'd2);
        check("mr_rd_before", 32'(fifo_rd), 32'd1);
        reset = 1'b0;
        #1;
        check("mr_rd_in_rst", 32'(fifo_rd), 32'd0);
        cyc();
        check("mr_valid", 32'(valid_out), 32'd0);
        check("mr_wc", 32'(word_count), 32'd0);
        check("mr_data", 32'(data_out), 32'd0);
        check("mr_idle", 32'(idle), 32'd1);
        check("mr_rd_held", 32'(fifo_rd), 32'd0);
        reset = 1'b1;
        enable = 1'b0;
        base = nlog;
        load(8'h01); load(8'h02);
        enable = 1'b1;
        #1;
        repeat (8) cyc();
        check("mr_count", 32'(7'(nlog - base)), 32'd2);
        check("mr_w0", 32'(log_mem[base]), 32'h01);
        check("mr_w1", 32'(log_mem[7'(base + 7'd1)]), 32'h02);
        check("mr_wc_after", 32'(word_count), 32'd2);

        // Counter wrap with a 4-bit counter: 17 words
        do_reset();
        enable = 1'b1;
        ready_in = 1'b1;
        base = nlog;
        wc15 = 4'h5;
        wc16 = 4'h5;
        for (int c = 0; c < 30; c++) begin
            push = (c < 17);
            push_data = 8'(c);
            #1;
            if (7'(nlog - base) == 7'd15) wc15 = word_count;
            if (7'(nlog - base) == 7'd16) wc16 = word_count;
            cyc();
        end
        push = 1'b0;
        check("wr_wc15", 32'(wc15), 32'd15);
        check("wr_wc16", 32'(wc16), 32'd0);
        check("wr_wc17", 32'(word_count), 32'd1);
        check("wr_count", 32'(7'(nlog - base)), 32'd17);
        errs = 0;
        for (int i = 0; i < 17; i++) begin
            if (log_mem[7'(base + 7'(i))] !== 8'(i)) errs++;
        end
        check("wr_order", 32'(errs), 32'd0);
        check("no_rd_on_empty", 32'(spurious), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
